i2cmb_wb_sequencer: RTL and testbench

I2CMB_WB_SEQUENCER -- requirements
Module: i2cmb_wb_sequencer

---
 rtl/i2cmb_wb_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_i2cmb_wb_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// i2cmb_wb_sequencer: runs one single-byte I2C read or write on an i2cmb core through its Wishbone CSR/DPR/CMDR port.
// Optional feature: define I2CMB_SEQ_IRQ_EN to wait for irq_i before each CMDR status read instead of polling.
module i2cmb_wb_sequencer #(
    parameter int unsigned POLL_GAP    = 4,
    parameter int unsigned CSR_BUS_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rw_i,
    input  logic [3:0] req_bus_i,
    input  logic [6:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic [1:0] rsp_err_o,
    output logic       cyc_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [1:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i,
    input  logic       irq_i
);

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;
    localparam logic [3:0] STEP_STOP = 4'd7;

    typedef enum logic [2:0] {INIT, IDLE, WB_ACC, WAIT_DONE, RESP} state_t;

    state_t     state;
    logic [3:0] step;
    logic       rw;
    logic [3:0] bus;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [1:0] err;
    logic       waiting;
    logic       polling;
    logic [7:0] gap;
    logic       poll_ok;
    logic [3:0] status;
    logic [7:0] csr_init;

`ifdef I2CMB_SEQ_IRQ_EN
    assign csr_init = 8'hC0;
    assign poll_ok  = irq_i;
`else
    // irq_i has no role when polling
    logic unused_irq;
    assign unused_irq = irq_i;
    assign csr_init   = 8'h80;
    assign poll_ok    = 1'b1;
`endif

    // status bits: [3]=DON [2]=NAK [1]=AL [0]=ERR
    assign status = dat_i[7:4];

    logic [1:0] s_adr;
    logic       s_we;
    logic [7:0] s_dat;
    logic       s_wait;

    always_comb begin
        s_adr  = ADR_CMDR;
        s_we   = 1'b1;
        s_dat  = '0;
        s_wait = 1'b0;
        case (step)
            4'd0: begin s_adr = ADR_DPR; s_dat = {4'b0, bus}; end
            4'd1: begin s_dat = 8'h05; s_wait = 1'b1; end
            4'd2: begin s_dat = 8'h02; s_wait = 1'b1; end
            4'd3: begin s_adr = ADR_DPR; s_dat = {addr, rw}; end
            4'd4: begin s_dat = 8'h03; s_wait = 1'b1; end
            4'd5: begin
                if (rw) begin s_dat = 8'h01; s_wait = 1'b1; end
                else    begin s_adr = ADR_DPR; s_dat = wdata; end
            end
            4'd6: begin
                if (rw) begin s_adr = ADR_DPR; s_we = 1'b0; end
                else    begin s_dat = 8'h03; s_wait = 1'b1; end
            end
            default: begin s_dat = 8'h04; s_wait = 1'b1; end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= INIT;
            step        <= '0;
            rw          <= 1'b0;
            bus         <= '0;
            addr        <= '0;
            wdata       <= '0;
            rdata       <= '0;
            err         <= '0;
            waiting     <= 1'b0;
            polling     <= 1'b0;
            gap         <= '0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= '0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (!cyc_o) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        adr_o <= ADR_CSR;
                        dat_o <= csr_init;
                    end else if (ack_i) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        we_o        <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        rw          <= req_rw_i;
                        bus         <= req_bus_i;
                        addr        <= req_addr_i;
                        wdata       <= req_data_i;
                        rdata       <= '0;
                        err         <= '0;
                        step        <= '0;
                        waiting     <= 1'b0;
                        gap         <= '0;
                        if (32'(req_bus_i) > CSR_BUS_MAX) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 2'b11;
                            rsp_data_o  <= '0;
                            state       <= RESP;
                        end else begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                // Also serves as the mandatory idle cycle between Wishbone accesses.
                WAIT_DONE: begin
                    if (!waiting) begin
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        we_o    <= s_we;
                        adr_o   <= s_adr;
                        dat_o   <= s_dat;
                        polling <= 1'b0;
                        state   <= WB_ACC;
                    end else if (gap != 8'd0) begin
                        gap <= gap - 8'd1;
                    end else if (poll_ok) begin
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        we_o    <= 1'b0;
                        adr_o   <= ADR_CMDR;
                        dat_o   <= '0;
                        polling <= 1'b1;
                        state   <= WB_ACC;
                    end
                end
                WB_ACC: begin
                    if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        if (polling) begin
                            if (status[1] || status[0]) begin
                                rsp_valid_o <= 1'b1;
                                rsp_err_o   <= status[1] ? 2'b10 : 2'b11;
                                rsp_data_o  <= '0;
                                state       <= RESP;
                            end else if (status == 4'd0) begin
                                gap   <= 8'(POLL_GAP - 1);
                                state <= WAIT_DONE;
                            end else if (step == STEP_STOP) begin
                                rsp_valid_o <= 1'b1;
                                rsp_err_o   <= err;
                                rsp_data_o  <= rw ? rdata : 8'h00;
                                state       <= RESP;
                            end else begin
                                // NAK jumps straight to Stop, remembering the error for the response
                                if (status[2]) begin
                                    err  <= 2'b01;
                                    step <= STEP_STOP;
                                end else begin
                                    step <= step + 4'd1;
                                end
                                waiting <= 1'b0;
                                state   <= WAIT_DONE;
                            end
                        end else begin
                            if (!we_o) rdata <= dat_i;
                            if (s_wait) begin
                                waiting <= 1'b1;
                                gap     <= '0;
                            end else begin
                                waiting <= 1'b0;
                                step    <= step + 4'd1;
                            end
                            state <= WAIT_DONE;
                        end
                    end
                end
                RESP: begin
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// tb_i2cmb_wb_sequencer: scoreboard bench with a Wishbone slave model that replays scripted CMDR status bytes.
`timescale 1ns/1ps
module tb_i2cmb_wb_sequencer;

    localparam int unsigned POLL_GAP = 3;
    localparam int unsigned BUS_MAX  = 7;
`ifdef I2CMB_SEQ_IRQ_EN
    localparam logic [7:0] CSR_INIT = 8'hC0;
`else
    localparam logic [7:0] CSR_INIT = 8'h80;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_rw_i = 1'b0;
    logic [3:0] req_bus_i = '0;
    logic [6:0] req_addr_i = '0;
    logic [7:0] req_data_i = '0;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic [1:0] rsp_err_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = '0;
    logic       ack_i = 1'b0;
    logic       irq_i = 1'b0;

    always #5 clk = ~clk;

    i2cmb_wb_sequencer #(.POLL_GAP(POLL_GAP), .CSR_BUS_MAX(BUS_MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
        .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] wr_q[$];
    logic [9:0] rsp_q[$];
    logic [7:0] status_q[$];
    logic [7:0] rd_val = 8'h00;
    int wr_seen = 0;
    int acc_seen = 0;
    int ack_cnt = 0;
    logic prev_rsp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave: acks each access on its second sampled cycle; CMDR reads pop the status script (default DON)
    always @(negedge clk) begin
        logic [7:0] st;
        if (rst) begin
            ack_i = 1'b0;
            ack_cnt = 0;
            irq_i = 1'b0;
        end else if (ack_i) begin
            ack_i = 1'b0;
            ack_cnt = 0;
            check_eq("cyc_drop", 32'(cyc_o), 32'd0);
        end else if (cyc_o && stb_o) begin
            ack_cnt++;
            if (ack_cnt == 2) begin
                ack_i = 1'b1;
                dat_i = 8'h00;
                acc_seen++;
                if (we_o) begin
                    wr_seen++;
                    if (wr_q.size() == 0) check_eq("wr_unexpected", 32'(we_o), 32'd0);
                    else check_eq("wr", 32'({adr_o, dat_o}), 32'(wr_q.pop_front()));
                    if (adr_o == 2'd2) irq_i = 1'b1;
                end else if (adr_o == 2'd2) begin
                    st = (status_q.size() != 0) ? status_q.pop_front() : 8'h80;
                    dat_i = st;
                    irq_i = (st[7:4] == 4'd0);
                end else if (adr_o == 2'd1) begin
                    dat_i = rd_val;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_rsp) check_eq("rsp_pulse", 32'(rsp_valid_o), 32'd0);
            if (rsp_valid_o) begin
                if (rsp_q.size() == 0) check_eq("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
                else check_eq("rsp", 32'({rsp_err_o, rsp_data_o}), 32'(rsp_q.pop_front()));
            end
        end
        prev_rsp = rsp_valid_o;
    end

    task automatic push_wr(input logic [1:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic exp_head(input logic [3:0] bus, input logic [6:0] a, input logic rw);
        push_wr(2'd1, {4'b0, bus});
        push_wr(2'd2, 8'h05);
        push_wr(2'd2, 8'h02);
        push_wr(2'd1, {a, rw});
        push_wr(2'd2, 8'h03);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready", 32'(req_ready_o), 32'd1);
    endtask

    task automatic send(input logic rw, input logic [3:0] bus, input logic [6:0] a, input logic [7:0] d);
        wait_ready();
        req_rw_i = rw;
        req_bus_i = bus;
        req_addr_i = a;
        req_data_i = d;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic finish_req();
        int n = 0;
        while (rsp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("rsp_pending", rsp_q.size(), 32'd0);
        check_eq("wr_pending", wr_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wb"}, 32'({cyc_o, stb_o, we_o, adr_o, dat_o}), 32'd0);
        check_eq({tag, "_ready"}, 32'(req_ready_o), 32'd0);
        check_eq({tag, "_rsp"}, 32'({rsp_valid_o, rsp_err_o, rsp_data_o}), 32'd0);
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        push_wr(2'd0, CSR_INIT);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_in_init", 32'(req_ready_o), 32'd0);
        wait_ready();
        check_eq("init_wr", wr_q.size(), 32'd0);

        // plain write
        exp_head(4'd2, 7'h22, 1'b0);
        push_wr(2'd1, 8'hA5); push_wr(2'd2, 8'h03); push_wr(2'd2, 8'h04);
        rsp_q.push_back({2'b00, 8'h00});
        send(1'b0, 4'd2, 7'h22, 8'hA5);
        finish_req();

        // read
        rd_val = 8'h3C;
        exp_head(4'd2, 7'h22, 1'b1);
        push_wr(2'd2, 8'h01); push_wr(2'd2, 8'h04);
        rsp_q.push_back({2'b00, 8'h3C});
        send(1'b1, 4'd2, 7'h22, 8'h00);
        finish_req();

        // NAK on address byte
        status_q = '{8'h80, 8'h80, 8'h40, 8'h80};
        exp_head(4'd3, 7'h22, 1'b0);
        push_wr(2'd2, 8'h04);
        rsp_q.push_back({2'b01, 8'h00});
        send(1'b0, 4'd3, 7'h22, 8'h99);
        finish_req();

        // empty status polls before DON
        status_q = '{8'h00, 8'h00, 8'h80};
        exp_head(4'd5, 7'h10, 1'b0);
        push_wr(2'd1, 8'h5A); push_wr(2'd2, 8'h03); push_wr(2'd2, 8'h04);
        rsp_q.push_back({2'b00, 8'h00});
        send(1'b0, 4'd5, 7'h10, 8'h5A);
        finish_req();

        // arbitration lost during Start: no Stop
        status_q = '{8'h80, 8'h20};
        push_wr(2'd1, 8'h01); push_wr(2'd2, 8'h05); push_wr(2'd2, 8'h02);
        rsp_q.push_back({2'b10, 8'h00});
        send(1'b0, 4'd1, 7'h30, 8'h11);
        finish_req();

        // CMDR ERR on Set Bus
        status_q = '{8'h10};
        push_wr(2'd1, 8'h04); push_wr(2'd2, 8'h05);
        rsp_q.push_back({2'b11, 8'h00});
        send(1'b1, 4'd4, 7'h30, 8'h00);
        finish_req();

        // illegal bus id
        base = acc_seen;
        rsp_q.push_back({2'b11, 8'h00});
        send(1'b0, 4'd15, 7'h22, 8'h11);
        @(negedge clk);
        check_eq("illegal_next", 32'(rsp_valid_o), 32'd1);
        check_eq("illegal_cyc", 32'(cyc_o), 32'd0);
        finish_req();
        repeat (4) @(negedge clk);
        check_eq("illegal_no_wb", acc_seen - base, 32'd0);

        // reset while the Start status poll is in flight
        base = wr_seen;
        push_wr(2'd1, 8'h02); push_wr(2'd2, 8'h05); push_wr(2'd2, 8'h02);
        send(1'b0, 4'd2, 7'h22, 8'hA5);
        n = 0;
        while (wr_seen < base + 3 && n < 500) begin @(negedge clk); n++; end
        n = 0;
        @(negedge clk);
        while (!cyc_o && n < 100) begin @(negedge clk); n++; end
        check_eq("rst_mid_cyc", 32'(cyc_o), 32'd1);
        check_eq("rst_mid_wr", wr_seen - base, 32'd3);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        status_q.delete();
        wr_q.delete();
        repeat (2) @(negedge clk);
        push_wr(2'd0, CSR_INIT);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_in_reinit", 32'(req_ready_o), 32'd0);
        wait_ready();
        check_eq("reinit_wr", wr_q.size(), 32'd0);

        // read after re-init
        rd_val = 8'h81;
        exp_head(4'd7, 7'h7F, 1'b1);
        push_wr(2'd2, 8'h01); push_wr(2'd2, 8'h04);
        rsp_q.push_back({2'b00, 8'h81});
        send(1'b1, 4'd7, 7'h7F, 8'h00);
        finish_req();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
